nmcu_pool_engine: RTL

- Parametrised pooling engine for the near-memory compute unit; generalises the fixed 2x2 MAXP descriptor op.
- Configurable window size, stride and mode (signed max or average) over an input map of up to MAX_INPUT_DIM x MAX_INPUT_DIM.
- Reads input elements from shared memory and writes pooled results back, using the existing sel/w_en/ready memory handshake on a shared tristate data bus.
- Sits beside the conv/relu datapaths and is launched by the NMCU sequencer.

---
 rtl/nmcu_pkg.sv | 44 ++++
 rtl/nmcu_pool_reduce.sv | 49 ++++
 rtl/nmcu_pool_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nmcu_pkg.sv
// Shared NMCU definitions: op codes, descriptor field widths, pooling mode and
// pooling-engine FSM encodings.
package nmcu_pkg;

    localparam int OPCODE_WIDTH    = 3;
    localparam int DESC_ADDR_WIDTH = 16;
    localparam int DESC_DIM_WIDTH  = 5;
    localparam int DESC_WIN_WIDTH  = 3;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP  = 3'd0,
        OP_CONV = 3'd1,
        OP_MAXP = 3'd2,
        OP_RELU = 3'd3,
        OP_AVGP = 3'd4
    } op_e;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } pool_state_e;

    // Index of the highest set bit; exact log2 for the power-of-two windows
    // that average mode accepts.
    function automatic int unsigned log2_floor(input logic [31:0] v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/nmcu_pool_reduce.sv
// Window reducer: keeps a running signed max or sum and presents the pooled
// result, shifted down by the window area for average mode.
module nmcu_pool_reduce
    import nmcu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int MAX_WINDOW  = 4,
    localparam int ACC_WIDTH   = DATA_WIDTH + 2 * $clog2(MAX_WINDOW),
    localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  pool_mode_e             mode,
    input  logic                   init,
    input  logic                   accumulate,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [DATA_WIDTH-1:0]  result
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] data_ext;

    assign data_ext = ACC_WIDTH'(signed'(data));

    always_comb begin
        acc_next = acc;
        if (init) begin
            acc_next = data_ext;
        end else if (mode == MODE_AVG) begin
            acc_next = acc + data_ext;
        end else if (data_ext > acc) begin
            acc_next = data_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accumulate) begin
            acc <= acc_next;
        end
    end

    // Arithmetic shift gives floor rounding for negative sums.
    assign result = (mode == MODE_AVG) ? DATA_WIDTH'(acc >>> shift) : acc[DATA_WIDTH-1:0];

endmodule

// File: rtl/nmcu_pool_engine.sv
// Configurable max/average pooling engine: walks each output window over the
// shared memory bus, reduces it and writes the pooled value back.
module nmcu_pool_engine
    import nmcu_pkg::*;
#(
    parameter  int ADDR_WIDTH    = 16,
    parameter  int DATABUS_WIDTH = 32,
    parameter  int MAX_INPUT_DIM = 15,
    parameter  int MAX_WINDOW    = 4,
    localparam int WIN_WIDTH     = $clog2(MAX_WINDOW) + 1,
    localparam int DIM_WIDTH     = $clog2(MAX_INPUT_DIM) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [WIN_WIDTH-1:0]     window,
    input  logic [WIN_WIDTH-1:0]     stride,
    input  logic [DIM_WIDTH-1:0]     in_w,
    input  logic [DIM_WIDTH-1:0]     in_h,
    input  logic [ADDR_WIDTH-1:0]    input_addr,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DIM_WIDTH-1:0]     out_w,
    output logic [DIM_WIDTH-1:0]     out_h,
    output logic                     mem_sel,
    output logic                     mem_w,
    output logic [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus,
    input  logic                     ready
);

    localparam int ACC_WIDTH   = DATABUS_WIDTH + 2 * $clog2(MAX_WINDOW);
    localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH);

    pool_state_e state, state_next;

    pool_mode_e            mode_r;
    logic [WIN_WIDTH-1:0]  k_r, s_r, kx, ky;
    logic [DIM_WIDTH-1:0]  in_w_r, in_h_r, ox, oy;
    logic [ADDR_WIDTH-1:0] in_base, out_base;
    logic                  err_r;

    logic [DIM_WIDTH-1:0]  k_dim, s_div, out_w_calc, out_h_calc;
    logic                  cfg_bad, window_last, output_last;
    logic [ADDR_WIDTH-1:0] rd_row, rd_col, rd_addr, wr_addr;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [DATABUS_WIDTH-1:0] result;

    assign k_dim = DIM_WIDTH'(k_r);
    assign s_div = (s_r == '0) ? DIM_WIDTH'(1) : DIM_WIDTH'(s_r);
    assign out_w_calc = (in_w_r - k_dim) / s_div + 1'b1;
    assign out_h_calc = (in_h_r - k_dim) / s_div + 1'b1;

    assign cfg_bad = (k_r == '0) || (s_r == '0) || (k_r > WIN_WIDTH'(MAX_WINDOW))
                  || (k_dim > in_w_r) || (k_dim > in_h_r)
                  || ((mode_r == MODE_AVG) && ((k_r & (k_r - 1'b1)) != '0));

    assign window_last = (kx == k_r - 1'b1) && (ky == k_r - 1'b1);
    assign output_last = (ox == out_w - 1'b1) && (oy == out_h - 1'b1);

    assign rd_row  = ADDR_WIDTH'(oy) * ADDR_WIDTH'(s_r) + ADDR_WIDTH'(ky);
    assign rd_col  = ADDR_WIDTH'(ox) * ADDR_WIDTH'(s_r) + ADDR_WIDTH'(kx);
    assign rd_addr = in_base + rd_row * ADDR_WIDTH'(in_w_r) + rd_col;
    assign wr_addr = out_base + ADDR_WIDTH'(oy) * ADDR_WIDTH'(out_w) + ADDR_WIDTH'(ox);

    assign shift = SHIFT_WIDTH'(2 * log2_floor(32'(k_r)));

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_sel     = 1'b0;
        mem_w       = 1'b0;
        address_bus = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                busy       = 1'b1;
                state_next = cfg_bad ? ST_DONE : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                busy        = 1'b1;
                mem_sel     = 1'b1;
                address_bus = rd_addr;
                if (ready) state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                busy       = 1'b1;
                state_next = window_last ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
                busy        = 1'b1;
                mem_sel     = 1'b1;
                mem_w       = 1'b1;
                address_bus = wr_addr;
                if (ready) state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                busy       = 1'b1;
                state_next = output_last ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign error    = done && err_r;
    assign data_bus = (mem_sel && mem_w) ? result : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= MODE_MAX;
            k_r      <= '0;
            s_r      <= '0;
            in_w_r   <= '0;
            in_h_r   <= '0;
            in_base  <= '0;
            out_base <= '0;
            err_r    <= 1'b0;
            out_w    <= '0;
            out_h    <= '0;
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r   <= pool_mode_e'(mode);
                        k_r      <= window;
                        s_r      <= stride;
                        in_w_r   <= in_w;
                        in_h_r   <= in_h;
                        in_base  <= input_addr;
                        out_base <= output_addr;
                    end
                end
                ST_CHECK: begin
                    err_r <= cfg_bad;
                    out_w <= cfg_bad ? '0 : out_w_calc;
                    out_h <= cfg_bad ? '0 : out_h_calc;
                    kx    <= '0;
                    ky    <= '0;
                    ox    <= '0;
                    oy    <= '0;
                end
                ST_RD_WAIT: begin
                    if (kx == k_r - 1'b1) begin
                        kx <= '0;
                        ky <= window_last ? '0 : ky + 1'b1;
                    end else begin
                        kx <= kx + 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (ox == out_w - 1'b1) begin
                        ox <= '0;
                        oy <= oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    nmcu_pool_reduce #(
        .DATA_WIDTH (DATABUS_WIDTH),
        .MAX_WINDOW (MAX_WINDOW)
    ) u_reduce (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode_r),
        .init       ((kx == '0) && (ky == '0)),
        .accumulate ((state == ST_RD_REQ) && ready),
        .shift      (shift),
        .data       (data_bus),
        .result     (result)
    );

endmodule
